menu_controller: RTL and testbench

Upstream control stage for the seven-segment display path. Debounces the five board buttons, runs the menu state machine that produces the 12-bit `menuState` code (100/200/300/400/410–450), and runs the error countdown that produces the 9-bit `seconds` bus (enable bit plus 0–99 value). Both outputs feed `segmentDisplay` directly and replace the ad-hoc button and seconds logic in the board test tops.

---
 rtl/menu_pkg.sv | 49 ++++
 rtl/menu_controller_if.sv | 22 ++
 rtl/button_debounce.sv | 51 +++++
 rtl/menu_controller.sv | 140 ++++++++++++++
 tb/tb_menu_controller.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/menu_pkg.sv
// Menu state codes, button indices and navigation helpers
// shared by the menu controller and its interface users.
package menu_pkg;

    typedef enum logic [11:0] {
        MENU_INPUT = 12'd100,
        MENU_GEN   = 12'd200,
        MENU_SHOW  = 12'd300,
        MENU_OP    = 12'd400,
        OP_T       = 12'd410,
        OP_ADD     = 12'd420,
        OP_SCALAR  = 12'd430,
        OP_MUL     = 12'd440,
        OP_CONV    = 12'd450
    } menu_state_e;

    localparam int BTN_NEXT  = 0;
    localparam int BTN_PREV  = 1;
    localparam int BTN_ENTER = 2;
    localparam int BTN_BACK  = 3;

    localparam logic [7:0] MAX_SECONDS = 8'd99;

    function automatic menu_state_e main_step(menu_state_e s, logic fwd);
        menu_state_e r;
        case (s)
            MENU_INPUT: r = fwd ? MENU_GEN   : MENU_OP;
            MENU_GEN:   r = fwd ? MENU_SHOW  : MENU_INPUT;
            MENU_SHOW:  r = fwd ? MENU_OP    : MENU_GEN;
            MENU_OP:    r = fwd ? MENU_INPUT : MENU_SHOW;
            default:    r = MENU_INPUT;
        endcase
        return r;
    endfunction

    function automatic menu_state_e sub_step(menu_state_e s, logic fwd);
        menu_state_e r;
        case (s)
            OP_T:      r = fwd ? OP_ADD    : OP_CONV;
            OP_ADD:    r = fwd ? OP_SCALAR : OP_T;
            OP_SCALAR: r = fwd ? OP_MUL    : OP_ADD;
            OP_MUL:    r = fwd ? OP_CONV   : OP_SCALAR;
            OP_CONV:   r = fwd ? OP_T      : OP_MUL;
            default:   r = MENU_INPUT;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/menu_controller_if.sv
// Button/error inputs and display-facing outputs of the
// menu controller; master drives inputs, slave is the controller.
interface menu_controller_if;

    logic [4:0]  btn_pin;
    logic        err_pulse;
    logic [7:0]  cfg_seconds;
    logic [11:0] menuState;
    logic [8:0]  seconds;
    logic [4:0]  btn_pulse;

    modport master (
        output btn_pin, err_pulse, cfg_seconds,
        input  menuState, seconds, btn_pulse
    );

    modport slave (
        input  btn_pin, err_pulse, cfg_seconds,
        output menuState, seconds, btn_pulse
    );

endinterface

// File: rtl/button_debounce.sv
// One button: two-flop synchronizer, hold-time debounce,
// and a single-cycle pulse on each accepted press.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic sys_rst_n,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          meta;
    logic          sync;
    logic [CW-1:0] cnt;

    // bring the asynchronous pin into the clock domain
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            meta <= 1'b0;
            sync <= 1'b0;
        end else begin
            meta <= raw;
            sync <= meta;
        end
    end

    // accept a new level only after it has held without a break
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
        end else begin
            press <= 1'b0;
            if (sync == level) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                cnt   <= '0;
                level <= sync;
                press <= sync;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/menu_controller.sv
// Debounced button navigation of the menu codes plus the
// error countdown that drives the seconds display bus.
module menu_controller
    import menu_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int TICK_CYCLES     = 50_000_000
) (
    input  logic              clk,
    input  logic              sys_rst_n,
    menu_controller_if.slave  bus
);

    localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);

    menu_state_e   state;
    menu_state_e   state_n;
    logic          secs_en;
    logic          en_n;
    logic [7:0]    secs_val;
    logic [7:0]    val_n;
    logic [TW-1:0] tick_cnt;
    logic [TW-1:0] tick_n;

    logic [4:0]    pulse;
    logic [4:0]    unused_level;
    logic [7:0]    load;

    logic ev_err;
    logic ev_back;
    logic ev_enter;
    logic ev_prev;
    logic ev_next;

    genvar i;
    generate
        for (i = 0; i < 5; i++) begin : g_btn
            button_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_db (
                .clk       (clk),
                .sys_rst_n (sys_rst_n),
                .raw       (bus.btn_pin[i]),
                .level     (unused_level[i]),
                .press     (pulse[i])
            );
        end
    endgenerate

    assign bus.btn_pulse = pulse;
    assign bus.menuState = state;
    assign bus.seconds   = {secs_en, secs_val};

    // one event per cycle; lower-priority events are dropped
    assign ev_err   = bus.err_pulse;
    assign ev_back  = pulse[BTN_BACK]  & ~ev_err;
    assign ev_enter = pulse[BTN_ENTER] & ~ev_err & ~ev_back;
    assign ev_prev  = pulse[BTN_PREV]  & ~ev_err & ~ev_back & ~ev_enter;
    assign ev_next  = pulse[BTN_NEXT]  & ~ev_err & ~ev_back & ~ev_enter
                    & ~ev_prev;

    assign load = (bus.cfg_seconds > MAX_SECONDS) ? MAX_SECONDS
                                                  : bus.cfg_seconds;

    // menu state, countdown value and tick phase registers
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state    <= MENU_INPUT;
            secs_en  <= 1'b0;
            secs_val <= '0;
            tick_cnt <= '0;
        end else begin
            state    <= state_n;
            secs_en  <= en_n;
            secs_val <= val_n;
            tick_cnt <= tick_n;
        end
    end

    // tick first, then let an acted-on event override it
    always_comb begin
        state_n = state;
        en_n    = secs_en;
        val_n   = secs_val;
        tick_n  = tick_cnt;

        if (secs_en) begin
            if (tick_cnt == TICK_LAST) begin
                tick_n = '0;
                val_n  = secs_val - 8'd1;
                if (secs_val == 8'd1) begin
                    en_n    = 1'b0;
                    state_n = MENU_OP;
                end
            end else begin
                tick_n = tick_cnt + 1'b1;
            end
        end

        case (state)
            MENU_INPUT, MENU_GEN, MENU_SHOW, MENU_OP: begin
                unique case (1'b1)
                    ev_next:  state_n = main_step(state, 1'b1);
                    ev_prev:  state_n = main_step(state, 1'b0);
                    ev_enter: if (state == MENU_OP) state_n = OP_T;
                    default: ;
                endcase
            end
            OP_T, OP_ADD, OP_SCALAR, OP_MUL, OP_CONV: begin
                unique case (1'b1)
                    ev_err: begin
                        if (bus.cfg_seconds != 8'd0) begin
                            state_n = state;
                            en_n    = 1'b1;
                            val_n   = load;
                            tick_n  = '0;
                        end
                    end
                    ev_back: begin
                        state_n = MENU_OP;
                        en_n    = 1'b0;
                        val_n   = '0;
                        tick_n  = '0;
                    end
                    ev_next: if (!secs_en) state_n = sub_step(state, 1'b1);
                    ev_prev: if (!secs_en) state_n = sub_step(state, 1'b0);
                    default: ;
                endcase
            end
            default: begin
                state_n = MENU_INPUT;
                en_n    = 1'b0;
                val_n   = '0;
                tick_n  = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_menu_controller.sv
// Directed scenarios plus random button/error traffic, checked
// every cycle against an index/arithmetic model of the menu.
module tb_menu_controller;

    localparam int DEB  = 8;
    localparam int TICK = 20;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    menu_controller_if bus();

    menu_controller #(
        .DEBOUNCE_CYCLES (DEB),
        .TICK_CYCLES     (TICK)
    ) dut (
        .clk       (clk),
        .sys_rst_n (rst_n),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int pcnt0 = 0;

    // model: menu position as indices, countdown as start edge
    int ecount = 0;
    int mi     = 0;
    int si     = 0;
    int rem    = 0;
    int start  = 0;
    bit in_sub = 0;
    bit active = 0;
    logic [4:0] m_pulse = '0;
    logic [4:0] m_level = '0;
    logic [4:0] r1 = '0;
    logic [4:0] r2 = '0;
    logic [DEB-1:0] hist [5];

    task automatic check(string name, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    function automatic int exp_state();
        return in_sub ? 410 + 10 * si : 100 * (mi + 1);
    endfunction

    function automatic int exp_secs();
        return (active ? 256 : 0) + rem;
    endfunction

    task automatic model_reset();
        ecount = 0; mi = 0; si = 0; rem = 0; start = 0;
        in_sub = 0; active = 0;
        m_pulse = '0; m_level = '0; r1 = '0; r2 = '0;
        for (int i = 0; i < 5; i++) hist[i] = '0;
    endtask

    task automatic model_step();
        bit e, b, en, p, n;
        bit do_tick;
        logic [4:0] nxt;
        int c;
        ecount++;
        e  = bus.err_pulse;
        b  = m_pulse[3] && !e;
        en = m_pulse[2] && !e && !b;
        p  = m_pulse[1] && !e && !b && !en;
        n  = m_pulse[0] && !e && !b && !en && !p;
        c  = int'(bus.cfg_seconds);
        do_tick = 1;
        if (!in_sub) begin
            if (n) mi = (mi + 1) % 4;
            else if (p) mi = (mi + 3) % 4;
            else if (en && mi == 3) begin in_sub = 1; si = 0; end
        end else if (e) begin
            if (c != 0) begin
                active = 1; rem = (c > 99) ? 99 : c; start = ecount;
                do_tick = 0;
            end
        end else if (b) begin
            in_sub = 0; mi = 3; active = 0; rem = 0; do_tick = 0;
        end else if (!active && n) begin
            si = (si + 1) % 5;
        end else if (!active && p) begin
            si = (si + 4) % 5;
        end
        if (do_tick && active && ((ecount - start) % TICK == 0)) begin
            rem--;
            if (rem == 0) begin active = 0; in_sub = 0; mi = 3; end
        end
        nxt = '0;
        for (int i = 0; i < 5; i++) begin
            hist[i] = {hist[i][DEB-2:0], r2[i]};
            if (hist[i] == {DEB{~m_level[i]}}) begin
                m_level[i] = ~m_level[i];
                nxt[i] = m_level[i];
            end
        end
        r2 = r1;
        r1 = bus.btn_pin;
        m_pulse = nxt;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            check("menuState", int'(bus.menuState), exp_state());
            check("seconds", int'(bus.seconds), exp_secs());
            check("btn_pulse", int'(bus.btn_pulse), int'(m_pulse));
        end
    end

    initial forever begin
        @(negedge clk);
        if (bus.btn_pulse[0] === 1'b1) pcnt0++;
    end

    task automatic cyc(int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic press(logic [4:0] m);
        @(negedge clk);
        bus.btn_pin = m;
        cyc(DEB + 4);
        bus.btn_pin = '0;
        cyc(DEB + 4);
    endtask

    task automatic err(logic [7:0] c);
        @(negedge clk);
        bus.cfg_seconds = c;
        bus.err_pulse   = 1'b1;
        @(negedge clk);
        bus.err_pulse   = 1'b0;
    endtask

    initial begin
        int exp_seq [4];
        exp_seq[0] = 200; exp_seq[1] = 300; exp_seq[2] = 400; exp_seq[3] = 100;
        bus.btn_pin     = '0;
        bus.err_pulse   = 1'b0;
        bus.cfg_seconds = '0;
        cyc(3);
        check("rst_state", int'(bus.menuState), 100);
        check("rst_secs", int'(bus.seconds), 0);
        check("rst_pulse", int'(bus.btn_pulse), 0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(2);

        for (int k = 0; k < 4; k++) begin
            pcnt0 = 0;
            press(5'b00001);
            check("next_seq", int'(bus.menuState), exp_seq[k]);
            check("next_pulse_w", pcnt0, 1);
        end

        pcnt0 = 0;
        @(negedge clk);
        bus.btn_pin = 5'b00001;
        cyc(3);
        bus.btn_pin = '0;
        cyc(DEB + 4);
        check("glitch_pulse", pcnt0, 0);
        check("glitch_state", int'(bus.menuState), 100);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            bus.btn_pin[0] = ~k[0];
        end
        press(5'b00001);
        check("bounce_pulse", pcnt0, 1);
        check("bounce_state", int'(bus.menuState), 200);

        err(8'd3);
        cyc(2);
        check("err_main", int'(bus.menuState), 200);
        check("err_main_s", int'(bus.seconds), 0);

        press(5'b00001);
        press(5'b00001);
        press(5'b00100);
        check("enter_op", int'(bus.menuState), 410);
        press(5'b00010);
        check("prev_wrap", int'(bus.menuState), 450);
        press(5'b00010);
        check("prev_440", int'(bus.menuState), 440);
        press(5'b01000);
        check("back_400", int'(bus.menuState), 400);

        press(5'b00100);
        press(5'b00001);
        check("at_420", int'(bus.menuState), 420);
        err(8'd3);
        check("cd_start", int'(bus.seconds), 'h103);
        cyc(20);
        check("cd_tick1", int'(bus.seconds), 'h102);
        cyc(20);
        check("cd_tick2", int'(bus.seconds), 'h101);
        cyc(20);
        check("cd_expire", int'(bus.seconds), 0);
        check("cd_exp_st", int'(bus.menuState), 400);

        press(5'b00100);
        press(5'b00001);
        err(8'd3);
        press(5'b00001);
        check("cd_no_next", int'(bus.menuState), 420);
        check("cd_no_next_s", int'(bus.seconds), 'h102);
        press(5'b01000);
        check("cd_abort", int'(bus.seconds), 0);
        check("cd_abort_st", int'(bus.menuState), 400);

        press(5'b00100);
        err(8'd150);
        check("clamp", int'(bus.seconds), 'h163);
        cyc(30);
        check("clamp_tick", int'(bus.seconds), 'h162);
        err(8'd150);
        check("restart", int'(bus.seconds), 'h163);
        cyc(19);
        check("fresh_phase", int'(bus.seconds), 'h163);
        cyc(1);
        check("fresh_tick", int'(bus.seconds), 'h162);
        press(5'b01000);
        check("abort2", int'(bus.seconds), 0);
        check("abort2_st", int'(bus.menuState), 400);

        press(5'b00100);
        press(5'b00001);
        press(5'b00001);
        check("at_430", int'(bus.menuState), 430);
        press(5'b01001);
        check("back_wins", int'(bus.menuState), 400);

        press(5'b00100);
        err(8'd5);
        cyc(10);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_state", int'(bus.menuState), 100);
        check("arst_secs", int'(bus.seconds), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            for (int b = 0; b < 5; b++)
                if ($urandom_range(0, 9) == 0) bus.btn_pin[b] = ~bus.btn_pin[b];
            bus.err_pulse = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 15) == 0)
                bus.cfg_seconds = ($urandom_range(0, 7) == 0)
                    ? 8'($urandom_range(0, 255))
                    : 8'($urandom_range(0, 4));
        end
        bus.btn_pin   = '0;
        bus.err_pulse = 1'b0;
        cyc(2 * DEB);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
